pc_ras_unit: RTL and testbench
==============================

Name: pc_ras_unit

Overview:
Parametrised successor to the 64-bit program counter. Registers the fetch PC and selects the next PC from: sequential, unconditional offset, conditional offset, register, call and return. Adds an N-entry return-address stack (RAS), an external redirect with priority, and a stall via enable. Sits at the head of fetch and drives the instruction-memory address.

Parameters:
WIDTH, 64, PC and datapath width in bits
RAS_DEPTH, 4, RAS entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset (WIDTH bits)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = advance PC/RAS; 0 = hold (stall)
redirect  input  1  force next PC to redirect_pc; overrides enable and pc_src
redirect_pc  input  WIDTH  redirect target
pc_src  input  3  next-PC mode; encoding in Behaviour
se_shifted_brAddr  input  WIDTH  sign-extended, <<2 unconditional offset
se_shifted_condAddr  input  WIDTH  sign-extended, <<2 conditional offset
reg_data  input  WIDTH  register target (BR / fallback return)
pc  output  WIDTH  current PC (registered)
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  output  1  sticky; set when a push drops the oldest entry
ras_underflow  output  1  one-cycle registered pulse on a pop from an empty RAS
ras_mispredict  output  1  one-cycle registered pulse (see Optional Feature)

Behaviour:
- Reset, synchronous and dominant over all inputs: pc=RESET_PC, ras_count=0, ras_overflow=0, ras_underflow=0, ras_mispredict=0. RAS entry contents are don't-care.
- pc_src encoding:
  - 000: pc+4
  - 001: pc+brAddr
  - 010: pc+condAddr
  - 011: reg_data
  - 100: CALL, next=pc+brAddr and push pc+4
  - 101: RET, next=RAS top and pop
  - 110/111: reserved, treated as 000
- All adds are modulo 2^WIDTH; carry is discarded.
- Priority order is reset > redirect > !enable > pc_src.
- Redirect: pc <= redirect_pc; RAS unchanged; pulses forced to 0.
- enable=0 (no redirect): pc, RAS, ras_count and ras_overflow hold; pulse outputs go to 0 next cycle.
- Latency: a mode/input change at posedge N appears on pc after posedge N+1. One PC update per enabled cycle.
- RAS is a circular buffer with a top pointer.
  - Push when ras_count<RAS_DEPTH: write at top+1, count++.
  - Push when full: overwrite the oldest entry (top wraps), count holds at RAS_DEPTH, ras_overflow<=1. ras_overflow clears only on reset.
  - RET with count>0: next=top entry, count--, top--.
  - RET with count==0: next=reg_data, count stays 0, ras_underflow pulses.
- ras_underflow and ras_mispredict are 0 on every cycle without their triggering event.

Optional Feature:
Macro RAS_CHECK_EN.
- Defined: on RET with count>0, compare top to reg_data.
  - Equal: next=top.
  - Not equal: next=reg_data and ras_mispredict pulses one cycle. The pop still occurs.
- Undefined: no comparator; RET uses top unconditionally; ras_mispredict tied 0.

Decomposition:
- Package pc_pkg:
  - pc_src_e enum (PC_SEQ, PC_UNCOND, PC_COND, PC_REG, PC_CALL, PC_RET)
  - PC_INCR=4
  - default RAS_DEPTH constant
- Sub-module ras_stack (params WIDTH, RAS_DEPTH):
  - inputs push, pop, push_data
  - outputs top_data, count, empty, full, overflow
  - pc_ras_unit keeps next-PC selection, the PC register and the pulse registers.
- The existing adder_64bit is used for WIDTH=64; behavioural + is used otherwise.

Test Plan:
1. Reset, then pc_src=000 for 3 enabled cycles -> pc 0, 4, 8, 0xC.
2. pc=0x10, brAddr=0x20, pc_src=001 -> pc=0x30. Then condAddr=-16 (all-ones ...F0), pc_src=010 -> pc=0x20.
3. CALL at pc=0x100 with brAddr=0x400 -> pc=0x500, ras_count=1. Then RET -> pc=0x104, ras_count=0, no pulses.
4. RAS_DEPTH=4: five CALLs from pc 0x0, 0x1000, 0x2000, 0x3000, 0x4000 (brAddr=0x1000 each) -> ras_overflow=1, count=4. Four RETs -> 0x4004, 0x3004, 0x2004, 0x1004. A fifth RET with reg_data=0xCAFE -> pc=0xCAFE, ras_underflow=1 for exactly one cycle.
5. Stall and redirect together:
   - enable=0 for 2 cycles with pc_src=100 -> pc and ras_count unchanged.
   - redirect=1, redirect_pc=0xABCD0000 while enable=0 -> pc=0xABCD0000 next cycle.
   - reset asserted mid-CALL -> pc=RESET_PC, count=0.
6. RAS_CHECK_EN defined: push 0x104, then RET with reg_data=0x200 -> pc=0x200, ras_mispredict=1 for one cycle. With reg_data=0x104 -> pc=0x104, ras_mispredict=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC / return-address-stack slice.
package pc_pkg;

  // Next-PC source; codes 6 and 7 are unused and fall back to sequential.
  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_UNCOND = 3'd1,
    PC_COND   = 3'd2,
    PC_REG    = 3'd3,
    PC_CALL   = 3'd4,
    PC_RET    = 3'd5
  } pc_src_e;

  localparam int unsigned PC_INCR           = 4;
  localparam int unsigned RAS_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/adder_64bit.sv
// 64-bit modulo adder used by the PC datapath when WIDTH is 64.
module adder_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/ras_stack.sv
// Circular return-address stack: a push on a full stack overwrites the oldest
// entry and raises a sticky overflow flag; a pop on an empty stack is ignored.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             top_data,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_inc;

  assign top_inc  = top + PW'(1);
  assign top_data = mem[top];
  assign empty    = (count == '0);
  assign full     = (count == CW'(RAS_DEPTH));

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      top      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (push) begin
      top <= top_inc;
      if (full) overflow <= 1'b1;
      else      count    <= count + CW'(1);
    end else if (pop && !empty) begin
      top   <= top - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Entry storage; on a full stack top+1 is the oldest slot, so it is replaced.
  always_ff @(posedge clk) begin
    if (push) mem[top_inc] <= push_data;
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch program counter with next-PC selection, return-address stack,
// external redirect and stall. Optional RAS target check: define RAS_CHECK_EN.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH     = 64,
  parameter int unsigned       RAS_DEPTH = RAS_DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_pc,
  input  logic [2:0]                 pc_src,
  input  logic [WIDTH-1:0]           se_shifted_brAddr,
  input  logic [WIDTH-1:0]           se_shifted_condAddr,
  input  logic [WIDTH-1:0]           reg_data,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow,
  output logic                       ras_mispredict
);

  localparam logic [WIDTH-1:0] INCR_W = WIDTH'(PC_INCR);

  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_br;
  logic [WIDTH-1:0] pc_cond;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             advance;
  logic             do_push;
  logic             do_pop;
  logic             underflow_nxt;
  logic             mispredict_nxt;

  // Offset adders: the dedicated 64-bit adder when it fits, plain + otherwise.
  if (WIDTH == 64) begin : g_add64
    adder_64bit u_add_seq  (.a(pc), .b(INCR_W),              .sum(pc_seq));
    adder_64bit u_add_br   (.a(pc), .b(se_shifted_brAddr),   .sum(pc_br));
    adder_64bit u_add_cond (.a(pc), .b(se_shifted_condAddr), .sum(pc_cond));
  end else begin : g_add_beh
    assign pc_seq  = pc + INCR_W;
    assign pc_br   = pc + se_shifted_brAddr;
    assign pc_cond = pc + se_shifted_condAddr;
  end

  assign advance = enable && !redirect;
  assign do_push = advance && (pc_src == PC_CALL);
  assign do_pop  = advance && (pc_src == PC_RET) && !ras_empty;

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_seq),
    .top_data  (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow)
  );

  // Next-PC mux and the pulse conditions raised by a return.
  always_comb begin
    next_pc        = pc_seq;
    underflow_nxt  = 1'b0;
    mispredict_nxt = 1'b0;
    case (pc_src)
      PC_UNCOND: next_pc = pc_br;
      PC_COND:   next_pc = pc_cond;
      PC_REG:    next_pc = reg_data;
      PC_CALL:   next_pc = pc_br;
      PC_RET: begin
        if (ras_empty) begin
          next_pc       = reg_data;
          underflow_nxt = 1'b1;
        end else begin
`ifdef RAS_CHECK_EN
          if (ras_top != reg_data) begin
            next_pc        = reg_data;
            mispredict_nxt = 1'b1;
          end else begin
            next_pc = ras_top;
          end
`else
          next_pc = ras_top;
`endif
        end
      end
      default:   next_pc = pc_seq;
    endcase
  end

  // PC register: reset, then redirect, then stall, then the selected source.
  always_ff @(posedge clk) begin
    if (reset)         pc <= RESET_PC;
    else if (redirect) pc <= redirect_pc;
    else if (enable)   pc <= next_pc;
  end

  // Single-cycle status pulses, only raised by an advancing return.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_underflow  <= 1'b0;
      ras_mispredict <= 1'b0;
    end else begin
      ras_underflow  <= advance && underflow_nxt;
      ras_mispredict <= advance && mispredict_nxt;
    end
  end

  // ras_full is only consumed inside the stack; kept visible for debug.
  logic unused_full;
  assign unused_full = ras_full;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed scenarios with literal
// expectations plus a randomized phase, all checked against a queue model.
module tb_pc_ras_unit;

  localparam int          WIDTH = 64;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h0;

  logic        clk = 1'b0;
  logic        reset, enable, redirect;
  logic [63:0] redirect_pc, br, cond, reg_data;
  logic [2:0]  pc_src;
  logic [63:0] pc;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow, ras_mispredict;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pc_ras_unit #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .pc_src              (pc_src),
    .se_shifted_brAddr   (br),
    .se_shifted_condAddr (cond),
    .reg_data            (reg_data),
    .pc                  (pc),
    .ras_count           (ras_count),
    .ras_overflow        (ras_overflow),
    .ras_underflow       (ras_underflow),
    .ras_mispredict      (ras_mispredict)
  );

  // Reference model: a plain queue as the stack, newest entry at the back.
  logic [63:0] m_pc;
  logic [63:0] m_q[$];
  bit          m_ovf, m_unf, m_mis;

  always @(posedge clk) begin
    logic [63:0] t;
    m_unf = 1'b0;
    m_mis = 1'b0;
    if (reset) begin
      m_pc = RPC;
      m_q.delete();
      m_ovf = 1'b0;
    end else if (redirect) begin
      m_pc = redirect_pc;
    end else if (enable) begin
      case (pc_src)
        3'd1: m_pc = m_pc + br;
        3'd2: m_pc = m_pc + cond;
        3'd3: m_pc = reg_data;
        3'd4: begin
          if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1'b1;
          end
          m_q.push_back(m_pc + 64'd4);
          m_pc = m_pc + br;
        end
        3'd5: begin
          if (m_q.size() == 0) begin
            m_pc  = reg_data;
            m_unf = 1'b1;
          end else begin
            t = m_q.pop_back();
`ifdef RAS_CHECK_EN
            if (t != reg_data) begin
              m_pc  = reg_data;
              m_mis = 1'b1;
            end else begin
              m_pc = t;
            end
`else
            m_pc = t;
`endif
          end
        end
        default: m_pc = m_pc + 64'd4;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_pc", pc, m_pc);
      chk("model_count", 64'(ras_count), 64'(m_q.size()));
      chk("model_ovf", 64'(ras_overflow), 64'(m_ovf));
      chk("model_unf", 64'(ras_underflow), 64'(m_unf));
      chk("model_mis", 64'(ras_mispredict), 64'(m_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; enable = 1'b1; redirect = 1'b0; redirect_pc = '0;
    pc_src = 3'd0; br = '0; cond = '0; reg_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic goto_pc(input logic [63:0] a);
    redirect = 1'b1; redirect_pc = a;
    step();
    redirect = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    chk_on = 1'b1;
    reset  = 1'b0;

    // Reset state and sequential fetch.
    chk("rst_pc", pc, 64'h0);
    chk("rst_count", 64'(ras_count), 64'd0);
    chk("rst_ovf", 64'(ras_overflow), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_pc", pc, 64'(4 * i));
    end

    // Unconditional and conditional offsets, including a negative one.
    goto_pc(64'h10);
    pc_src = 3'd1; br = 64'h20;
    step();
    chk("uncond_pc", pc, 64'h30);
    pc_src = 3'd2; cond = 64'hFFFF_FFFF_FFFF_FFF0;
    step();
    chk("cond_pc", pc, 64'h20);

    // Call and return pair.
    goto_pc(64'h100);
    pc_src = 3'd4; br = 64'h400;
    step();
    chk("call_pc", pc, 64'h500);
    chk("call_count", 64'(ras_count), 64'd1);
    pc_src = 3'd5; reg_data = 64'h104;
    step();
    chk("ret_pc", pc, 64'h104);
    chk("ret_count", 64'(ras_count), 64'd0);
    chk("ret_unf", 64'(ras_underflow), 64'd0);

    // Overflow with five calls, drain, then underflow.
    do_reset();
    pc_src = 3'd4; br = 64'h1000;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("chain_call_pc", pc, 64'(64'h1000 * i));
    end
    chk("chain_ovf", 64'(ras_overflow), 64'd1);
    chk("chain_count", 64'(ras_count), 64'd4);
    pc_src = 3'd5;
    for (int i = 0; i < 4; i++) begin
      reg_data = 64'h4004 - 64'(64'h1000 * i);
      step();
      chk("chain_ret_pc", pc, 64'h4004 - 64'(64'h1000 * i));
    end
    reg_data = 64'hCAFE;
    step();
    chk("unf_pc", pc, 64'hCAFE);
    chk("unf_pulse", 64'(ras_underflow), 64'd1);
    chk("unf_ovf_sticky", 64'(ras_overflow), 64'd1);
    pc_src = 3'd0;
    step();
    chk("unf_clear", 64'(ras_underflow), 64'd0);

    // Stall, redirect during stall, reset during a call.
    goto_pc(64'h200);
    pc_src = 3'd4; br = 64'h40; enable = 1'b0;
    step();
    step();
    chk("stall_pc", pc, 64'h200);
    chk("stall_count", 64'(ras_count), 64'd0);
    redirect = 1'b1; redirect_pc = 64'hABCD0000;
    step();
    chk("redir_pc", pc, 64'hABCD0000);
    chk("redir_count", 64'(ras_count), 64'd0);
    redirect = 1'b0; enable = 1'b1;
    step();
    chk("call_after_redir", 64'(ras_count), 64'd1);
    reset = 1'b1;
    step();
    chk("midcall_rst_pc", pc, RPC);
    chk("midcall_rst_count", 64'(ras_count), 64'd0);
    chk("midcall_rst_ovf", 64'(ras_overflow), 64'd0);
    reset = 1'b0;

`ifdef RAS_CHECK_EN
    // Return target check against the register value.
    goto_pc(64'h100);
    pc_src = 3'd4; br = 64'h400;
    step();
    pc_src = 3'd5; reg_data = 64'h200;
    step();
    chk("mis_pc", pc, 64'h200);
    chk("mis_pulse", 64'(ras_mispredict), 64'd1);
    chk("mis_count", 64'(ras_count), 64'd0);
    goto_pc(64'h100);
    pc_src = 3'd4;
    step();
    pc_src = 3'd5; reg_data = 64'h104;
    step();
    chk("hit_pc", pc, 64'h104);
    chk("hit_pulse", 64'(ras_mispredict), 64'd0);
`endif

    // Randomized phase checked only by the model.
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 99) < 2);
      redirect    = ($urandom_range(0, 99) < 5);
      enable      = ($urandom_range(0, 99) < 80);
      redirect_pc = {32'($urandom), 32'($urandom)};
      pc_src      = 3'($urandom_range(0, 7));
      if (($urandom_range(0, 2) == 0) && (pc_src < 3'd4)) pc_src = 3'($urandom_range(4, 5));
      br          = 64'($signed(32'($urandom_range(0, 255)) - 32'd128)) <<< 2;
      cond        = 64'($signed(32'($urandom_range(0, 255)) - 32'd128)) <<< 2;
      if ((m_q.size() > 0) && $urandom_range(0, 1)) reg_data = m_q[m_q.size() - 1];
      else reg_data = {32'($urandom), 32'($urandom)};
      step();
    end

    idle_inputs();
    step();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
